// File: rtl/alu_issue_stage.sv
// Decode/issue stage ahead of the ALU: owns the register file and a busy scoreboard that stalls RAW hazards.
// Optional define ALU_ISSUE_BYPASS_EN forwards a same-cycle writeback straight into the operands being issued.
module alu_issue_stage #(
    parameter int PENDING_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_op,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [15:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_illegal,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data
);

    localparam int PW = $clog2(PENDING_MAX + 1);

    typedef enum logic [3:0] {
        OP_ADD     = 4'd0,
        OP_ADDU    = 4'd1,
        OP_SUB     = 4'd2,
        OP_SUBU    = 4'd3,
        OP_AND     = 4'd4,
        OP_OR      = 4'd5,
        OP_SLL     = 4'd6,
        OP_SRL     = 4'd7,
        OP_SLT     = 4'd8,
        OP_ADDI    = 4'd9,
        OP_ADDIU   = 4'd10,
        OP_ANDI    = 4'd11,
        OP_ORI     = 4'd12,
        OP_SLTI    = 4'd13,
        OP_ILLEGAL = 4'd15
    } alu_op_e;

    logic [31:0]   regs [32];
    logic [31:0]   busy;
    logic [31:0]   busy_next;
    logic [PW-1:0] pending;
    logic [PW-1:0] pending_next;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    alu_op_e     dec_op;
    logic        dec_illegal;
    logic        dec_shift;
    logic        dec_itype;
    logic        use_rs;
    logic        use_rt;
    logic [4:0]  dec_dest;
    logic        rs_fwd;
    logic        rt_fwd;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        rs_busy;
    logic        rt_busy;
    logic        pend_full;
    logic        hazard;
    logic        accept;
    logic        issue;
    logic        wb_hit;

    assign opcode = in_instr[31:26];
    assign rs     = in_instr[25:21];
    assign rt     = in_instr[20:16];
    assign rd     = in_instr[15:11];
    assign shamt  = in_instr[10:6];
    assign funct  = in_instr[5:0];

    always_comb begin
        dec_op = OP_ILLEGAL;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20:   dec_op = OP_ADD;
                    6'h21:   dec_op = OP_ADDU;
                    6'h22:   dec_op = OP_SUB;
                    6'h23:   dec_op = OP_SUBU;
                    6'h24:   dec_op = OP_AND;
                    6'h25:   dec_op = OP_OR;
                    6'h00:   dec_op = OP_SLL;
                    6'h02:   dec_op = OP_SRL;
                    6'h2A:   dec_op = OP_SLT;
                    default: dec_op = OP_ILLEGAL;
                endcase
            end
            6'h08:   dec_op = OP_ADDI;
            6'h09:   dec_op = OP_ADDIU;
            6'h0C:   dec_op = OP_ANDI;
            6'h0D:   dec_op = OP_ORI;
            6'h0A:   dec_op = OP_SLTI;
            default: dec_op = OP_ILLEGAL;
        endcase
    end

    // Shifts read only rt, I-type only rs; an illegal word reads and writes nothing.
    assign dec_illegal = (dec_op == OP_ILLEGAL);
    assign dec_shift   = (dec_op == OP_SLL) || (dec_op == OP_SRL);
    assign dec_itype   = (dec_op >= OP_ADDI) && !dec_illegal;
    assign use_rs      = !dec_illegal && !dec_shift;
    assign use_rt      = !dec_illegal && !dec_itype;
    assign dec_dest    = dec_illegal ? 5'd0 : (dec_itype ? rt : rd);

`ifdef ALU_ISSUE_BYPASS_EN
    assign rs_fwd = wb_en && (wb_addr == rs) && (rs != 5'd0);
    assign rt_fwd = wb_en && (wb_addr == rt) && (rt != 5'd0);
`else
    assign rs_fwd = 1'b0;
    assign rt_fwd = 1'b0;
`endif

    assign rs_val = (rs == 5'd0) ? 32'd0 : (rs_fwd ? wb_data : regs[rs]);
    assign rt_val = (rt == 5'd0) ? 32'd0 : (rt_fwd ? wb_data : regs[rt]);

    assign rs_busy   = use_rs && (rs != 5'd0) && busy[rs] && !rs_fwd;
    assign rt_busy   = use_rt && (rt != 5'd0) && busy[rt] && !rt_fwd;
    assign pend_full = (dec_dest != 5'd0) && (pending == PW'(PENDING_MAX));
    assign hazard    = rs_busy || rt_busy || pend_full;

    assign in_ready = (!out_valid || out_ready) && !hazard;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && (dec_dest != 5'd0);
    assign wb_hit   = wb_en && (wb_addr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Clear first so that an issue to the register being written back on the same edge keeps it busy.
    always_comb begin
        busy_next = busy;
        if (wb_hit) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (issue) begin
            busy_next[dec_dest] = 1'b1;
        end
    end

    always_comb begin
        pending_next = pending;
        if (issue && !(wb_hit && (pending != '0))) begin
            pending_next = pending + PW'(1);
        end else if (!issue && wb_hit && (pending != '0)) begin
            pending_next = pending - PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 32'd0;
            pending <= '0;
        end else begin
            busy    <= busy_next;
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_op      <= 4'd0;
            out_a       <= 32'd0;
            out_b       <= 32'd0;
            out_imm     <= 16'd0;
            out_rd      <= 5'd0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_op      <= dec_op;
            out_a       <= dec_illegal ? 32'd0 : (dec_shift ? rt_val : rs_val);
            out_b       <= (use_rs && use_rt) ? rt_val : 32'd0;
            out_imm     <= dec_itype ? in_instr[15:0] : (dec_shift ? {11'd0, shamt} : 16'd0);
            out_rd      <= dec_dest;
            out_illegal <= dec_illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/issue stage directly upstream of the combinational ALU ops (ADD/ADDU/SUB/SUBU/AND/OR/SLL/SRL/SLT/ADDI/ADDIU/ANDI/ORI/SLTI).
- Accepts 32-bit MIPS instruction words over valid/ready and decodes them into an ALU op select, operand A/B, immediate and destination.
- Owns the 32x32 register file, written back from the ALU result port.
- A per-register busy scoreboard plus an in-flight counter stall RAW hazards.

Parameters:
PENDING_MAX, 4, max in-flight register writes (issued, not yet written back); range 1..15

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  instruction word valid
in_ready  output  1  stage accepts in_instr this cycle
in_instr  input  32  MIPS instruction word
out_valid  output  1  decoded op valid toward ALU
out_ready  input  1  ALU side consumes op
out_op  output  4  0 ADD,1 ADDU,2 SUB,3 SUBU,4 AND,5 OR,6 SLL,7 SRL,8 SLT,9 ADDI,10 ADDIU,11 ANDI,12 ORI,13 SLTI,15 illegal
out_a  output  32  operand A (rs value; rt value for SLL/SRL)
out_b  output  32  operand B (rt value; 0 for I-type and shifts)
out_imm  output  16  instr[15:0] for I-type; {11'b0,shamt} for shifts; 0 otherwise
out_rd  output  5  destination (rd for R-type, rt for I-type)
out_illegal  output  1  unsupported opcode/funct
wb_en  input  1  ALU result writeback strobe
wb_addr  input  5  writeback register
wb_data  input  32  writeback value

Behaviour:
- Reset (async, immediate): all regs, busy[31:0], pending counter and out_* = 0; in_ready may assert first cycle after release.
- Decode: opcode 0 with funct 0x20/21/22/23/24/25/00/02/2A -> ops 0..8. Opcodes 0x08/09/0C/0D/0A -> ops 9..13. Anything else -> op 15, out_illegal=1.
- Sources: R-type arithmetic/logic use rs, rt. Shifts use rt only. I-type uses rs only. Illegal uses none.
- Hazard = any used source (nonzero) has busy set, or dest≠0 and pending==PENDING_MAX.
- in_ready = (!out_valid | out_ready) & !hazard. Combinational on in_instr and state.
- Accept (in_valid & in_ready): output register loads on the next edge. Latency 1 cycle.
- Output hold: out_* stable while out_valid & !out_ready. out_valid clears after handshake if nothing new is accepted.
- Issue: on accept with dest≠0 and not illegal, set busy[dest] and pending+1.
- Writeback: wb_en with wb_addr≠0 writes regfile, clears busy[wb_addr], pending-1. Writes to $0 are ignored; $0 always reads 0.
- Same-edge set and clear on one register: set wins; pending is unchanged (+1 and -1 cancel).
- Pending saturates at 0 on a spurious wb; never exceeds PENDING_MAX.
- A second in-flight write to a busy dest is allowed (WAW). busy clears on the first matching wb; the ALU side guarantees in-order wb.
- Register read happens at accept time; values are captured into out_a/out_b.
- Reset mid-operation: pending op dropped, scoreboard cleared, regfile zeroed.

Optional Feature:
ALU_ISSUE_BYPASS_EN
- Defined: a source matching wb_addr (≠0) with wb_en in the same cycle is treated as not busy. wb_data is forwarded into out_a/out_b on that accept.
- Undefined: no forwarding. The instruction stalls through the wb cycle and is accepted the following cycle from the regfile (+1 cycle per RAW).

Test Plan:
- wb r1=5, r2=7; issue 0x00221820 (ADD r3,r1,r2) -> next cycle out_valid=1, op=0, a=5, b=7, rd=3, busy[3]=1, pending=1.
- issue 0x2024FFFF (ADDI r4,r1,-1) -> op=9, a=5, b=0, imm=0xFFFF, rd=4. Then 0x00023100 (SLL r6,r2,4) -> op=6, a=7, imm=0x0004, rd=6.
- ADD r3 in flight, present SUB r5,r3,r1 (0x00612822) -> in_ready=0 until wb r3=12. With BYPASS_EN accepted in wb cycle with a=12; without, accepted one cycle later, a=12.
- issue 0xFC000000 -> out_illegal=1, op=15, busy and pending unchanged. Then out_ready=0 for 3 cycles -> out_* held stable, in_ready=0.
- issue 4 independent writes (r7..r10) with no wb -> 5th with dest≠0 stalls (pending=4). wb r7 -> accepted next cycle. Assert rst mid-stall -> out_valid=0, pending=0, busy=0 immediately.
